// File: rtl/restoring_divider.sv
// restoring_divider: sequential unsigned restoring divider, one quotient bit per clock,
// valid/ready handshakes on both sides; divide by zero returns all-ones quotient and rem = a.
module restoring_divider #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quot,
  output logic [N-1:0] rem,
  output logic         div_zero
);
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [N-1:0] p, p_nx, dvd, dvs, q;
  logic [N:0] p_sh;
  logic accept, ge, last;
  // The remainder after a subtract is always below the divisor, so N bits of P suffice
  assign p_sh = {p, dvd[N-1]};
  assign ge = p_sh >= {1'b0, dvs};
  assign p_nx = ge ? N'(p_sh - {1'b0, dvs}) : p_sh[N-1:0];
  assign last = cnt == CW'(N - 1);
  assign accept = in_valid && in_ready;
  always_comb begin
    state_nx = state;
    in_ready = state == IDLE;
    out_valid = state == DONE;
    case (state)
      IDLE: state_nx = accept ? (b == '0 ? DONE : CALC) : IDLE;
      CALC: state_nx = last ? DONE : CALC;
      DONE: state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      p <= '0;
      dvd <= '0;
      dvs <= '0;
      q <= '0;
      quot <= '0;
      rem <= '0;
      div_zero <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
      p <= '0;
      dvd <= a;
      dvs <= b;
      q <= '0;
      if (b == '0) begin
        quot <= '1;
        rem <= a;
        div_zero <= 1'b1;
      end
    end else if (state == CALC) begin
      cnt <= cnt + 1'b1;
      p <= p_nx;
      dvd <= dvd << 1;
      q <= {q[N-2:0], ge};
      if (last) begin
        quot <= {q[N-2:0], ge};
        rem <= p_nx;
        div_zero <= 1'b0;
      end
    end
  end
endmodule
